uart_io_controller: RTL and testbench

UART_IO_CONTROLLER -- requirements
Module: uart_io_controller

---
 rtl/uart_io_controller.sv | 157 +++++++++++++++
 tb/tb_uart_io_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_io_controller.sv
// Stalling UART I/O sequencer for UARTtoReg / RegtoUART writeback instructions.
// Optional 4-entry receive prefetch FIFO enabled by defining UART_RX_PREFETCH_EN.
module uart_io_controller #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 UARTtoReg,
    input  logic                 RegtoUART,
    input  logic [31:0]          register_data,
    input  logic                 input_ready,
    input  logic [31:0]          rx_word,
    input  logic                 output_busy,
    output logic                 rx_pop,
    output logic [31:0]          input_data,
    output logic                 UART_write_enable,
    output logic [31:0]          tx_data,
    output logic                 stall,
    output logic                 io_done,
    output logic [CNT_WIDTH-1:0] stall_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX_WAIT = 3'd1,
        RX_DONE = 3'd2,
        TX_WAIT = 3'd3,
        TX_DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] input_data_d, tx_data_d;
    logic        word_avail_s;
    logic [31:0] head_word_s;
    logic        capture_raw_s, capture_s;
    logic        stall_raw_s;

    // Combinational strobes are forced low while reset is held.
    assign capture_s = capture_raw_s & reset;
    assign stall     = stall_raw_s & reset;

`ifdef UART_RX_PREFETCH_EN
    logic [31:0] fifo_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  count_q;
    logic        full_s, push_s;

    assign full_s       = (count_q == 3'd4);
    assign word_avail_s = (count_q != 3'd0);
    assign head_word_s  = fifo_q[rd_ptr_q];
    // A full FIFO still accepts a word in the cycle its head is consumed.
    assign push_s       = reset & input_ready & (~full_s | capture_s);
    assign rx_pop       = push_s;

    // Prefetch FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) fifo_q[i] <= 32'd0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push_s) fifo_q[wr_ptr_q] <= rx_word;
            wr_ptr_q <= wr_ptr_q + {1'b0, push_s};
            rd_ptr_q <= rd_ptr_q + {1'b0, capture_s};
            count_q  <= count_q + {2'b00, push_s} - {2'b00, capture_s};
        end
    end
`else
    assign word_avail_s = input_ready;
    assign head_word_s  = rx_word;
    assign rx_pop       = capture_s;
`endif

    // Next-state, capture and stall decode.
    always_comb begin
        state_d       = state_q;
        input_data_d  = input_data;
        tx_data_d     = tx_data;
        capture_raw_s = 1'b0;
        stall_raw_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (UARTtoReg) begin
                    stall_raw_s = 1'b1;
                    if (word_avail_s) begin
                        capture_raw_s = 1'b1;
                        input_data_d  = head_word_s;
                        state_d       = RX_DONE;
                    end else begin
                        state_d = RX_WAIT;
                    end
                end else if (RegtoUART) begin
                    stall_raw_s = 1'b1;
                    if (!output_busy) begin
                        tx_data_d = register_data;
                        state_d   = TX_DONE;
                    end else begin
                        state_d = TX_WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RX_WAIT: begin
                stall_raw_s = 1'b1;
                if (word_avail_s) begin
                    capture_raw_s = 1'b1;
                    input_data_d  = head_word_s;
                    state_d       = RX_DONE;
                end else begin
                    state_d = RX_WAIT;
                end
            end
            TX_WAIT: begin
                stall_raw_s = 1'b1;
                if (!output_busy) begin
                    tx_data_d = register_data;
                    state_d   = TX_DONE;
                end else begin
                    state_d = TX_WAIT;
                end
            end
            RX_DONE: state_d = IDLE;
            TX_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and data registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            input_data <= 32'd0;
            tx_data    <= 32'd0;
        end else begin
            state_q    <= state_d;
            input_data <= input_data_d;
            tx_data    <= tx_data_d;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= {CNT_WIDTH{1'b0}};
        end else if (stall && (stall_count != {CNT_WIDTH{1'b1}})) begin
            stall_count <= stall_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            stall_count <= stall_count;
        end
    end

    assign io_done           = (state_q == RX_DONE) || (state_q == TX_DONE);
    assign UART_write_enable = (state_q == TX_DONE);

endmodule

// File: tb/tb_uart_io_controller.sv
// Directed self-checking bench for uart_io_controller (small counter width for saturation).
module tb_uart_io_controller;

    logic        clk, reset, UARTtoReg, RegtoUART, input_ready, output_busy;
    logic [31:0] register_data, rx_word;
    logic        rx_pop, UART_write_enable, stall, io_done;
    logic [31:0] input_data, tx_data;
    logic [3:0]  stall_count;
    int          vectors = 0;
    int          miscompares = 0;

    uart_io_controller #(.CNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .UARTtoReg(UARTtoReg), .RegtoUART(RegtoUART),
        .register_data(register_data), .input_ready(input_ready), .rx_word(rx_word),
        .output_busy(output_busy), .rx_pop(rx_pop), .input_data(input_data),
        .UART_write_enable(UART_write_enable), .tx_data(tx_data), .stall(stall),
        .io_done(io_done), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset;
        reset = 1'b0; UARTtoReg = 1'b0; RegtoUART = 1'b0; input_ready = 1'b0; output_busy = 1'b0;
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0; UARTtoReg = 1'b1; RegtoUART = 1'b0; input_ready = 1'b1; output_busy = 1'b0;
        rx_word = 32'h0BAD_F00D; register_data = 32'h0;
        #1;
        vectors++; if (input_data !== 32'h0) begin miscompares++; $display("FAIL rst_input_data: got %h exp %h", input_data, 32'h0); end
        vectors++; if (tx_data !== 32'h0) begin miscompares++; $display("FAIL rst_tx_data: got %h exp %h", tx_data, 32'h0); end
        vectors++; if (stall_count !== 4'h0) begin miscompares++; $display("FAIL rst_stall_count: got %h exp %h", stall_count, 4'h0); end
        vectors++; if ({rx_pop, stall, io_done, UART_write_enable} !== 4'b0000) begin miscompares++; $display("FAIL rst_strobes: got %b exp %b", {rx_pop, stall, io_done, UART_write_enable}, 4'b0000); end
        @(negedge clk); reset = 1'b1; UARTtoReg = 1'b0; input_ready = 1'b0;
    endtask

    task automatic test_rx_immediate;
        @(negedge clk); UARTtoReg = 1'b1; input_ready = 1'b1; rx_word = 32'h5555_5555; #1;
        vectors++; if ({rx_pop, stall} !== 2'b11) begin miscompares++; $display("FAIL rx_imm_pop_stall: got %b exp %b", {rx_pop, stall}, 2'b11); end
        @(negedge clk); UARTtoReg = 1'b0; input_ready = 1'b0; #1;
        vectors++; if (input_data !== 32'h5555_5555) begin miscompares++; $display("FAIL rx_imm_data: got %h exp %h", input_data, 32'h5555_5555); end
        vectors++; if ({io_done, stall, rx_pop} !== 3'b100) begin miscompares++; $display("FAIL rx_imm_done: got %b exp %b", {io_done, stall, rx_pop}, 3'b100); end
        vectors++; if (stall_count !== 4'd1) begin miscompares++; $display("FAIL rx_imm_count: got %0d exp %0d", stall_count, 1); end
        @(negedge clk); #1;
        vectors++; if (io_done !== 1'b0) begin miscompares++; $display("FAIL rx_imm_done_clr: got %b exp %b", io_done, 1'b0); end
    endtask

    task automatic test_rx_wait;
        apply_reset();
        UARTtoReg = 1'b1; input_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++; if ({stall, rx_pop} !== 2'b10) begin miscompares++; $display("FAIL rx_wait_cyc%0d: got %b exp %b", i, {stall, rx_pop}, 2'b10); end
            @(negedge clk);
        end
        input_ready = 1'b1; rx_word = 32'h1234_5678; #1;
        vectors++; if ({stall, rx_pop} !== 2'b11) begin miscompares++; $display("FAIL rx_wait_capture: got %b exp %b", {stall, rx_pop}, 2'b11); end
        @(negedge clk); UARTtoReg = 1'b0; input_ready = 1'b0; #1;
        vectors++; if (input_data !== 32'h1234_5678) begin miscompares++; $display("FAIL rx_wait_data: got %h exp %h", input_data, 32'h1234_5678); end
        vectors++; if (stall_count !== 4'd6) begin miscompares++; $display("FAIL rx_wait_count: got %0d exp %0d", stall_count, 6); end
        vectors++; if ({io_done, stall} !== 2'b10) begin miscompares++; $display("FAIL rx_wait_done: got %b exp %b", {io_done, stall}, 2'b10); end
    endtask

    task automatic test_drop_request;
        @(negedge clk); UARTtoReg = 1'b1; input_ready = 1'b0; #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL drop_stall0: got %b exp %b", stall, 1'b1); end
        @(negedge clk); UARTtoReg = 1'b0; #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL drop_stall1: got %b exp %b", stall, 1'b1); end
        @(negedge clk); input_ready = 1'b1; rx_word = 32'hA5A5_A5A5; #1;
        vectors++; if (rx_pop !== 1'b1) begin miscompares++; $display("FAIL drop_pop: got %b exp %b", rx_pop, 1'b1); end
        @(negedge clk); input_ready = 1'b0; #1;
        vectors++; if (input_data !== 32'hA5A5_A5A5) begin miscompares++; $display("FAIL drop_data: got %h exp %h", input_data, 32'hA5A5_A5A5); end
        vectors++; if (io_done !== 1'b1) begin miscompares++; $display("FAIL drop_done: got %b exp %b", io_done, 1'b1); end
    endtask

    task automatic test_tx_immediate;
        @(negedge clk); RegtoUART = 1'b1; output_busy = 1'b0; register_data = 32'h0F0F_0F0F; #1;
        vectors++; if ({stall, UART_write_enable} !== 2'b10) begin miscompares++; $display("FAIL tx_imm_req: got %b exp %b", {stall, UART_write_enable}, 2'b10); end
        @(negedge clk); RegtoUART = 1'b0; register_data = 32'h0; #1;
        vectors++; if ({UART_write_enable, io_done, stall} !== 3'b110) begin miscompares++; $display("FAIL tx_imm_we: got %b exp %b", {UART_write_enable, io_done, stall}, 3'b110); end
        vectors++; if (tx_data !== 32'h0F0F_0F0F) begin miscompares++; $display("FAIL tx_imm_data: got %h exp %h", tx_data, 32'h0F0F_0F0F); end
    endtask

    task automatic test_tx_wait;
        @(negedge clk); RegtoUART = 1'b1; output_busy = 1'b1; register_data = 32'hAAAA_AAAA;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if ({stall, UART_write_enable} !== 2'b10) begin miscompares++; $display("FAIL tx_wait_cyc%0d: got %b exp %b", i, {stall, UART_write_enable}, 2'b10); end
            @(negedge clk);
        end
        output_busy = 1'b0; #1;
        vectors++; if ({stall, UART_write_enable} !== 2'b10) begin miscompares++; $display("FAIL tx_wait_exit: got %b exp %b", {stall, UART_write_enable}, 2'b10); end
        @(negedge clk); RegtoUART = 1'b0; #1;
        vectors++; if ({UART_write_enable, io_done, stall} !== 3'b110) begin miscompares++; $display("FAIL tx_wait_we: got %b exp %b", {UART_write_enable, io_done, stall}, 3'b110); end
        vectors++; if (tx_data !== 32'hAAAA_AAAA) begin miscompares++; $display("FAIL tx_wait_data: got %h exp %h", tx_data, 32'hAAAA_AAAA); end
        @(negedge clk); #1;
        vectors++; if (UART_write_enable !== 1'b0) begin miscompares++; $display("FAIL tx_wait_we_clr: got %b exp %b", UART_write_enable, 1'b0); end
    endtask

    task automatic test_both;
        @(negedge clk); UARTtoReg = 1'b1; RegtoUART = 1'b1; input_ready = 1'b1;
        rx_word = 32'hDEAD_BEEF; register_data = 32'h1111_1111; output_busy = 1'b0; #1;
        vectors++; if (rx_pop !== 1'b1) begin miscompares++; $display("FAIL both_pop: got %b exp %b", rx_pop, 1'b1); end
        @(negedge clk); UARTtoReg = 1'b0; RegtoUART = 1'b0; input_ready = 1'b0; #1;
        vectors++; if (input_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL both_data: got %h exp %h", input_data, 32'hDEAD_BEEF); end
        vectors++; if (UART_write_enable !== 1'b0) begin miscompares++; $display("FAIL both_no_we: got %b exp %b", UART_write_enable, 1'b0); end
        @(negedge clk); #1;
        vectors++; if ({UART_write_enable, tx_data} !== {1'b0, 32'hAAAA_AAAA}) begin miscompares++; $display("FAIL both_tx_idle: got %b/%h exp %b/%h", UART_write_enable, tx_data, 1'b0, 32'hAAAA_AAAA); end
    endtask

    task automatic test_saturation;
        apply_reset();
        UARTtoReg = 1'b1; input_ready = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        vectors++; if ({stall, stall_count} !== {1'b1, 4'hF}) begin miscompares++; $display("FAIL sat_count: got %b/%h exp %b/%h", stall, stall_count, 1'b1, 4'hF); end
        input_ready = 1'b1; rx_word = 32'h0000_0077;
        @(negedge clk); UARTtoReg = 1'b0; input_ready = 1'b0; #1;
        vectors++; if ({io_done, stall_count} !== {1'b1, 4'hF}) begin miscompares++; $display("FAIL sat_hold: got %b/%h exp %b/%h", io_done, stall_count, 1'b1, 4'hF); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk); UARTtoReg = 1'b1; input_ready = 1'b0;
        @(negedge clk); #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL rmid_in_wait: got %b exp %b", stall, 1'b1); end
        reset = 1'b0; input_ready = 1'b1; rx_word = 32'hCAFE_0001; #1;
        vectors++; if ({stall, rx_pop, io_done} !== 3'b000) begin miscompares++; $display("FAIL rmid_strobes: got %b exp %b", {stall, rx_pop, io_done}, 3'b000); end
        vectors++; if (stall_count !== 4'h0) begin miscompares++; $display("FAIL rmid_count: got %h exp %h", stall_count, 4'h0); end
        @(negedge clk); reset = 1'b1; UARTtoReg = 1'b0; input_ready = 1'b0; #1;
        vectors++; if ({stall, io_done, UART_write_enable, input_data} !== {3'b000, 32'h0}) begin miscompares++; $display("FAIL rmid_after: got %b%b%b/%h exp 000/%h", stall, io_done, UART_write_enable, input_data, 32'h0); end
    endtask

`ifdef UART_RX_PREFETCH_EN
    task automatic test_prefetch;
        logic [31:0] w;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            w = 32'h0000_0100 + 32'(i);
            input_ready = 1'b1; rx_word = w; #1;
            vectors++; if (rx_pop !== (i < 4)) begin miscompares++; $display("FAIL pf_push%0d: got %b exp %b", i, rx_pop, (i < 4)); end
            @(negedge clk);
        end
        input_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            UARTtoReg = 1'b1; #1;
            vectors++; if (rx_pop !== 1'b0) begin miscompares++; $display("FAIL pf_nopop%0d: got %b exp %b", k, rx_pop, 1'b0); end
            @(negedge clk); UARTtoReg = 1'b0; #1;
            w = 32'h0000_0100 + 32'(k);
            vectors++; if ({io_done, input_data} !== {1'b1, w}) begin miscompares++; $display("FAIL pf_word%0d: got %b/%h exp 1/%h", k, io_done, input_data, w); end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef UART_RX_PREFETCH_EN
        test_tx_immediate();
        test_tx_wait();
        test_reset_mid();
        test_prefetch();
`else
        test_rx_immediate();
        test_rx_wait();
        test_drop_request();
        test_tx_immediate();
        test_tx_wait();
        test_both();
        test_saturation();
        test_reset_mid();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
